arb_hold_lsb: RTL

Registered, grant-holding arbiter built around a combinational LSB-first fixed-priority picker. Up to REQ_WIDTH requesters compete for one shared resource. The lowest-indexed active request wins and keeps the grant until it releases, drops its request, or hits a hold-time limit. It sits directly downstream of the combinational picker and drives the shared-resource mux select (one-hot and binary index).

---
 rtl/arb_hold_lsb_pkg.sv | 12 +
 rtl/arb_hold_lsb_if.sv | 14 +
 rtl/arb_lsb_pick.sv | 15 +
 rtl/arb_hold_lsb.sv | 69 ++++++
 4 files changed

// File: rtl/arb_hold_lsb_pkg.sv
// arb_hold_lsb_pkg: shared arbiter state type and one-hot to index encode
package arb_hold_lsb_pkg;
  localparam int OH_MAX = 256;
  localparam int IDX_MAX_W = 8;
  typedef enum logic {IDLE, HOLD} arb_state_e;
  function automatic logic [IDX_MAX_W-1:0] oh2idx(input logic [OH_MAX-1:0] oh);
    logic [IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < OH_MAX; i++) idx |= oh[i] ? IDX_MAX_W'(i) : '0;
    return idx;
  endfunction
endpackage

// File: rtl/arb_hold_lsb_if.sv
// arb_hold_lsb_if: request/grant bundle; master drives req/rel, slave drives gnt/gnt_vld/gnt_idx/timeout
interface arb_hold_lsb_if #(
  parameter int REQ_WIDTH = 16,
  parameter int IDX_W = $clog2(REQ_WIDTH)
);
  logic [REQ_WIDTH-1:0] req;
  logic rel;
  logic [REQ_WIDTH-1:0] gnt;
  logic gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic timeout;
  modport master (output req, rel, input gnt, gnt_vld, gnt_idx, timeout);
  modport slave (input req, rel, output gnt, gnt_vld, gnt_idx, timeout);
endinterface

// File: rtl/arb_lsb_pick.sv
// arb_lsb_pick: combinational fixed-priority picker, bit 0 wins; req in, one-hot gnt out
module arb_lsb_pick #(
  parameter int REQ_WIDTH = 16
) (
  input  logic [REQ_WIDTH-1:0] req,
  output logic [REQ_WIDTH-1:0] gnt
);
  // lower[i] is set when any bit below i is requesting
  logic [REQ_WIDTH-1:0] lower;
  assign lower[0] = 1'b0;
  for (genvar i = 1; i < REQ_WIDTH; i++) begin : g_chain
    assign lower[i] = lower[i-1] | req[i-1];
  end
  assign gnt = req & ~lower;
endmodule

// File: rtl/arb_hold_lsb.sv
// arb_hold_lsb: registered grant-holding LSB-first arbiter with hold-time limit
// clk/rst: clock and sync active-high reset; bus (slave): req/rel in, gnt/gnt_vld/gnt_idx/timeout out
module arb_hold_lsb #(
  parameter int REQ_WIDTH = 16,
  parameter int MAX_HOLD = 8
) (
  input logic clk,
  input logic rst,
  arb_hold_lsb_if.slave bus
);
  import arb_hold_lsb_pkg::*;
  localparam int IDX_W = $clog2(REQ_WIDTH);
  localparam int CNT_W = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
  arb_state_e state, state_nxt;
  logic [REQ_WIDTH-1:0] pick, gnt_q, gnt_nxt;
  logic [IDX_W-1:0] pick_idx, idx_q, idx_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic to_q, to_nxt, drop, expire, free;
  arb_lsb_pick #(.REQ_WIDTH(REQ_WIDTH)) u_pick (.req(bus.req), .gnt(pick));
  assign pick_idx = IDX_W'(oh2idx(OH_MAX'(pick)));
  always_comb begin
    drop = ~|(bus.req & gnt_q);
    expire = (MAX_HOLD != 0) && (cnt_q == CNT_LAST);
    free = bus.rel | drop | expire;
    state_nxt = state;
    gnt_nxt = gnt_q;
    idx_nxt = idx_q;
    cnt_nxt = cnt_q;
    to_nxt = 1'b0;
    if (state == IDLE) begin
      if (|bus.req) begin
        state_nxt = HOLD;
        gnt_nxt = pick;
        idx_nxt = pick_idx;
        cnt_nxt = '0;
      end
    end else if (free) begin
      state_nxt = IDLE;
      gnt_nxt = '0;
      idx_nxt = '0;
      cnt_nxt = '0;
      // flag only a release forced purely by the hold limit
      to_nxt = expire & ~bus.rel & ~drop;
    end else begin
      cnt_nxt = cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt_q <= gnt_nxt;
      idx_q <= idx_nxt;
      cnt_q <= cnt_nxt;
      to_q <= to_nxt;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.gnt_vld = |gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.timeout = to_q;
endmodule
